// File: rtl/bus_resp_pkg.sv
// Shared types for the bus responder: read FSM states and the posted-write buffer entry.
package bus_resp_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W     = 8;

  typedef enum logic [2:0] {
    IDLE,
    RD_DRAIN,
    RD_REQ,
    RD_WAIT,
    RD_DONE
  } state_t;

  // Entry address field is sized for ADDR_W_DEF; the responder is built with ADDR_W <= ADDR_W_DEF.
  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wbuf_entry_t;

endpackage

// File: rtl/bus_resp_wbuf.sv
// Posted-write FIFO for the bus responder; with BUS_RESP_WRITE_FWD_EN it also reports the
// youngest buffered entry whose address matches look_addr.
module bus_resp_wbuf
  import bus_resp_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data
`ifdef BUS_RESP_WRITE_FWD_EN
  ,
  input  logic [ADDR_W-1:0] look_addr,
  output logic              hit,
  output logic [DATA_W-1:0] hit_data
`endif
);

  localparam int PW = $clog2(DEPTH);

  wbuf_entry_t   entries [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count;
  logic          pop_ok;
  logic          push_ok;

  assign full      = (count == (PW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign pop_ok    = pop && !empty;
  // A push into a full buffer is accepted when the head leaves on the same edge.
  assign push_ok   = push && (!full || pop_ok);
  assign head_addr = ADDR_W'(entries[rd_ptr].addr);
  assign head_data = entries[rd_ptr].data;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) entries[wr_ptr] <= '{addr: ADDR_W_DEF'(push_addr), data: push_data};
  end

`ifdef BUS_RESP_WRITE_FWD_EN
  logic [PW-1:0] idx;

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if (((PW+1)'(i) < count) && (ADDR_W'(entries[idx].addr) == look_addr)) begin
        hit      = 1'b1;
        hit_data = entries[idx].data;
      end
    end
  end
`endif

endmodule

// File: rtl/bus_responder.sv
// Memory-side responder for the core bus: posted writes, RDY-stalled reads, one backing port.
// Optional feature macro: BUS_RESP_WRITE_FWD_EN (read forwarding from the write buffer).
module bus_responder
  import bus_resp_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int WBUF_DEPTH = 4,
  parameter int MIN_WAIT   = 0
) (
  input  logic              PHI0,
  input  logic              RES,
  input  logic              CYC,
  input  logic [ADDR_W-1:0] A,
  input  logic              RnW,
  input  logic [DATA_W-1:0] DB_in,
  output logic [DATA_W-1:0] DB_out,
  output logic              RDY,
  output logic              WB_OVF,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [3:0]        wait_cnt;
  logic              wb_full;
  logic              wb_empty;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              push;
  logic              pop;
  logic              accept_rd;
  logic              rd_go;
  logic              drain_go;
  logic              done_go;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  bus_resp_wbuf #(
    .ADDR_W (ADDR_W),
    .DEPTH  (WBUF_DEPTH)
  ) u_wbuf (
    .clk       (PHI0),
    .rst       (RES),
    .push      (push),
    .push_addr (A),
    .push_data (DB_in),
    .pop       (pop),
    .full      (wb_full),
    .empty     (wb_empty),
    .head_addr (head_addr),
    .head_data (head_data)
`ifdef BUS_RESP_WRITE_FWD_EN
    ,
    .look_addr (A),
    .hit       (fwd_hit),
    .hit_data  (fwd_data)
`endif
  );

`ifdef BUS_RESP_WRITE_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

  always_ff @(posedge PHI0) begin
    if (RES) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    push      = CYC && !RnW;
    pop       = mem_req && mem_we && mem_ack;
    accept_rd = CYC && RnW && RDY;
    // Forwarding makes a missed read alias-free, so it may overtake buffered writes.
    rd_go     = (state == RD_DRAIN) && !mem_req && (FWD_EN || wb_empty);
    drain_go  = !mem_req && !wb_empty && !rd_go && !(FWD_EN && accept_rd && !fwd_hit);

    state_next = state;
    unique case (state)
      IDLE, RD_DONE: begin
        state_next = IDLE;
        if (accept_rd) state_next = fwd_hit ? RD_WAIT : RD_DRAIN;
      end
      RD_DRAIN: if (rd_go) state_next = RD_REQ;
      RD_REQ:   if (mem_req && mem_ack) state_next = (MIN_WAIT == 0) ? RD_DONE : RD_WAIT;
      RD_WAIT:  if (wait_cnt == '0) state_next = RD_DONE;
      default:  state_next = IDLE;
    endcase
    done_go = (state_next == RD_DONE);
  end

  // Control and core/memory-facing outputs.
  always_ff @(posedge PHI0) begin
    if (RES) begin
      RDY       <= 1'b1;
      DB_out    <= '0;
      WB_OVF    <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if (accept_rd) RDY <= 1'b0;
      if (done_go) begin
        RDY    <= 1'b1;
        DB_out <= (state == RD_REQ) ? mem_rdata : rd_data;
      end
      if (push && wb_full && !pop) WB_OVF <= 1'b1;
      if (mem_req && mem_ack) mem_req <= 1'b0;
      if (rd_go) begin
        mem_req  <= 1'b1;
        mem_we   <= 1'b0;
        mem_addr <= rd_addr;
      end else if (drain_go) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b1;
        mem_addr  <= head_addr;
        mem_wdata <= head_data;
      end
    end
  end

  // Read address/data capture and slow-ROM wait counter.
  always_ff @(posedge PHI0) begin
    if (accept_rd) begin
      rd_addr  <= A;
      rd_data  <= fwd_data;
      wait_cnt <= '0;
    end
    if ((state == RD_REQ) && mem_req && mem_ack) begin
      rd_data  <= mem_rdata;
      wait_cnt <= 4'(MIN_WAIT - 1);
    end else if (state == RD_WAIT) begin
      wait_cnt <= wait_cnt - 1'b1;
    end
  end

endmodule
